byte_path_arbiter: RTL

- Round-robin arbiter that shares one 8-bit byte datapath between NUM_REQ independent requesters.
- Grants one requester at a time for a bounded burst and forwards its bytes through a single registered output stage.
- Tags each output byte with its source index and keeps a free-running accepted-byte counter.
- Sits in front of the 8-bit core datapath (data_in side) and sequences which producer drives it.

---
 rtl/byte_path_arbiter_pkg.sv | 17 +
 rtl/byte_path_arbiter_if.sv | 33 +++
 rtl/byte_path_arbiter_rr_pick.sv | 29 ++
 rtl/byte_path_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/byte_path_arbiter_pkg.sv
// Shared types and constants for the byte path arbiter.
package byte_path_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int XFER_CNT_W         = 16;

    // Increment a requester index with wrap at n.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/byte_path_arbiter_if.sv
// Requester/downstream bus of the byte path arbiter.
interface byte_path_arbiter_if
    import byte_path_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int SRC_W = $clog2(NUM_REQ);

    // Every channel transfers on a rising clk edge where valid && ready; a
    // producer's data must be valid whenever its valid is high, and the
    // output stage holds out_valid/out_data/out_src until out_ready.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]              out_src;
    logic                          out_ready;
    logic                          busy;
    logic [XFER_CNT_W-1:0]         xfer_count;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, busy, xfer_count
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, busy, xfer_count
    );

endinterface

// File: rtl/byte_path_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_req
);
    logic found;
    int   idx;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant_idx = SRC_W'(idx);
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req_valid;

endmodule

// File: rtl/byte_path_arbiter.sv
// Round-robin arbiter sharing one byte datapath between NUM_REQ producers,
// with bounded bursts, a single registered output stage and a transfer counter.
module byte_path_arbiter
    import byte_path_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    byte_path_arbiter_if.slave bus,
    output state_t             dbg_state
);
    localparam int SRC_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = 8;

    state_t                  state;
    logic [SRC_W-1:0]        grant;
    logic [SRC_W-1:0]        rr_ptr;
    logic [SRC_W-1:0]        pick_idx;
    logic [BEAT_W-1:0]       beat_cnt;
    logic                    any_req;
    logic                    busy;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [SRC_W-1:0]        out_src;
    logic [XFER_CNT_W-1:0]   xfer_count;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    can_take;
    logic                    grant_valid;
    logic                    accept;
    logic                    burst_done;
    logic [DATA_WIDTH-1:0]   grant_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // The output register can take a byte when empty or draining this cycle.
    always_comb begin
        can_take    = !out_valid || bus.out_ready;
        grant_valid = bus.req_valid[grant];
        grant_byte  = bus.req_data[grant*DATA_WIDTH +: DATA_WIDTH];
        accept      = (state == GRANT) && can_take && grant_valid;
        burst_done  = (beat_cnt + 1'b1) == BEAT_W'(MAX_BURST);
        req_ready   = '0;
        if ((state == GRANT) && can_take) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_done) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= SRC_W'(next_idx(int'(grant), NUM_REQ));
                        end
                    end else if (can_take) begin
                        // Granted source went idle while it could have sent.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= SRC_W'(next_idx(int'(grant), NUM_REQ));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            xfer_count <= '0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_data   <= grant_byte;
                out_src    <= grant;
                xfer_count <= xfer_count + 1'b1;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_src    = out_src;
    assign bus.busy       = busy;
    assign bus.xfer_count = xfer_count;
    assign dbg_state      = state;

endmodule
